// File: rtl/ocp_pkg.sv
// ocp_pkg: OCP command and response encodings shared by the slave and its benches
package ocp_pkg;
  localparam logic [2:0] MCMD_IDLE  = 3'b000;
  localparam logic [2:0] MCMD_WRITE = 3'b001;
  localparam logic [2:0] MCMD_READ  = 3'b010;
  localparam logic [2:0] MCMD_WRC   = 3'b110;
  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_FAIL = 2'b10;
  localparam logic [1:0] SRESP_ERR  = 2'b11;
endpackage

// File: rtl/ocp_slave_ram.sv
// ocp_slave_ram: DEPTH x 32 word RAM, byte-enable synchronous write, asynchronous read, no reset
module ocp_slave_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ocp_slave_mem.sv
// ocp_slave_mem: single-thread OCP slave over a word RAM with programmable accept wait states.
// Define OCP_WRITE_RESP_EN to give every accepted legal WRITE a one-cycle DVA response.
module ocp_slave_mem
  import ocp_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ACCEPT_WAIT = 0
) (
  input  logic        Clk_i,
  input  logic        MReset_ni,
  input  logic [2:0]  MCmd_i,
  input  logic [15:0] MAddr_i,
  input  logic [3:0]  MByteEn_i,
  input  logic [31:0] MData_i,
  output logic        SCmdAccept_o,
  output logic [1:0]  SResp_o,
  output logic [31:0] SData_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef OCP_WRITE_RESP_EN
  localparam logic [1:0] WR_RESP = SRESP_DVA;
`else
  localparam logic [1:0] WR_RESP = SRESP_NULL;
`endif
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] data_q, data_d, rdata;
  logic [13:0] idx;
  logic        req, bad, we;
  assign idx = MAddr_i[15:2];
  assign req = MCmd_i != MCMD_IDLE;
  // accept is gated by reset so nothing is taken while the link is held in reset
  assign SCmdAccept_o = MReset_ni && req && wait_cnt_q == 4'(ACCEPT_WAIT);
  assign bad = (|MAddr_i[1:0]) || 32'(idx) >= DEPTH;
  assign we = SCmdAccept_o && !bad && MCmd_i == MCMD_WRITE;
  always_comb begin
    wait_cnt_d = (!req || SCmdAccept_o) ? 4'd0 : wait_cnt_q + 4'd1;
    resp_d = !SCmdAccept_o          ? SRESP_NULL :
             bad                    ? SRESP_ERR  :
             MCmd_i == MCMD_READ    ? SRESP_DVA  :
             MCmd_i == MCMD_WRITE   ? WR_RESP    :
             MCmd_i == MCMD_WRC     ? SRESP_FAIL : SRESP_ERR;
    data_d = (SCmdAccept_o && !bad && MCmd_i == MCMD_READ) ? rdata : 32'd0;
  end
  always_ff @(posedge Clk_i or negedge MReset_ni)
    if (!MReset_ni) begin
      wait_cnt_q <= 4'd0;
      resp_q     <= SRESP_NULL;
      data_q     <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      resp_q     <= resp_d;
      data_q     <= data_d;
    end
  ocp_slave_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (Clk_i),
    .we_i    (we),
    .addr_i  (idx[AW-1:0]),
    .be_i    (MByteEn_i),
    .wdata_i (MData_i),
    .rdata_o (rdata)
  );
  assign SResp_o = resp_q;
  assign SData_o = data_q;
endmodule
